// File: rtl/multi_alloc_queue.sv
// multi_alloc_queue: circular in-order slot allocator.
// Packs a sparse request mask contiguously from the tail using prefix-sum
// lane offsets, retires entries in order from the head, and supports a
// full flush that drops every live entry.

// prefix_sum: inclusive running sum across NUM_INPUT fields of INPUT_SIZE bits.
module prefix_sum #(
  parameter int NUM_INPUT   = 4,
  parameter int INPUT_SIZE  = 1,
  parameter int OUTPUT_SIZE = 3
) (
  input  logic [NUM_INPUT*INPUT_SIZE-1:0]  data,
  output logic [NUM_INPUT*OUTPUT_SIZE-1:0] sum
);

  logic [OUTPUT_SIZE-1:0] acc;

  // Ripple accumulation; NUM_INPUT is small so a linear chain is adequate.
  always_comb begin
    acc = '0;
    sum = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      acc = acc + OUTPUT_SIZE'(data[i*INPUT_SIZE +: INPUT_SIZE]);
      sum[i*OUTPUT_SIZE +: OUTPUT_SIZE] = acc;
    end
  end

endmodule

module multi_alloc_queue #(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_ENTRY = 16,
  localparam int PTR_W     = $clog2(NUM_ENTRY),
  localparam int CNT_W     = $clog2(NUM_REQ) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic                     alloc_grant,
  output logic [NUM_REQ*PTR_W-1:0] alloc_tag,
  input  logic [CNT_W-1:0]         rel_cnt,
  input  logic                     flush,
  output logic                     rel_err,
  output logic [PTR_W-1:0]         head_ptr,
  output logic [PTR_W-1:0]         tail_ptr,
  output logic [PTR_W:0]           count,
  output logic                     full,
  output logic                     empty
);

  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(NUM_ENTRY);

  logic [NUM_REQ*CNT_W-1:0] incl_flat;
  logic [CNT_W-1:0]         total;
  logic [PTR_W:0]           free_cnt;
  logic [PTR_W:0]           total_ext;
  logic [PTR_W:0]           rel_ext;
  logic                     rel_legal;
  logic [PTR_W:0]           alloc_amt;
  logic [PTR_W:0]           rel_amt;

  prefix_sum #(
    .NUM_INPUT  (NUM_REQ),
    .INPUT_SIZE (1),
    .OUTPUT_SIZE(CNT_W)
  ) u_prefix (
    .data(req_valid),
    .sum (incl_flat)
  );

  assign total = incl_flat[(NUM_REQ-1)*CNT_W +: CNT_W];

  // Each requesting lane lands at tail + number of requesting lanes below it.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tag
    logic [CNT_W-1:0] excl;
    assign excl = incl_flat[g*CNT_W +: CNT_W] - CNT_W'(req_valid[g]);
    assign alloc_tag[g*PTR_W +: PTR_W] = tail_ptr + PTR_W'(excl);
  end

  // Free space uses registered count only, so rel_cnt stays off the grant path.
  always_comb begin
    total_ext   = (PTR_W+1)'(total);
    rel_ext     = (PTR_W+1)'(rel_cnt);
    free_cnt    = DEPTH - count;
    alloc_grant = !flush && (total_ext <= free_cnt);
    rel_legal   = (rel_ext <= count);
    alloc_amt   = alloc_grant ? total_ext : '0;
    rel_amt     = rel_legal ? rel_ext : '0;
  end

  // Pointer/count update; flush outranks allocate and release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      rel_err  <= 1'b0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      count    <= '0;
      rel_err  <= 1'b0;
    end else begin
      tail_ptr <= tail_ptr + PTR_W'(alloc_amt);
      head_ptr <= head_ptr + PTR_W'(rel_amt);
      count    <= count + alloc_amt - rel_amt;
      rel_err  <= !rel_legal;
    end
  end

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

endmodule

// File: tb/tb_multi_alloc_queue.sv
// Bench for multi_alloc_queue: directed test-plan steps followed by random
// traffic, all checked against an abstract queue model (integers, modulo math).
module tb_multi_alloc_queue;

  localparam int NR = 4;
  localparam int NE = 16;
  localparam int PW = 4;
  localparam int CW = 3;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic            alloc_grant;
  logic [NR*PW-1:0] alloc_tag;
  logic [CW-1:0]   rel_cnt;
  logic            flush;
  logic            rel_err;
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [PW:0]     count;
  logic            full;
  logic            empty;

  int checks   = 0;
  int failures = 0;

  int m_head  = 0;
  int m_tail  = 0;
  int m_count = 0;
  int m_err   = 0;

  multi_alloc_queue #(.NUM_REQ(NR), .NUM_ENTRY(NE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .alloc_grant(alloc_grant),
    .alloc_tag  (alloc_tag),
    .rel_cnt    (rel_cnt),
    .flush      (flush),
    .rel_err    (rel_err),
    .head_ptr   (head_ptr),
    .tail_ptr   (tail_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_head"},  int'(head_ptr), m_head);
    chk({tag, "_tail"},  int'(tail_ptr), m_tail);
    chk({tag, "_count"}, int'(count),    m_count);
    chk({tag, "_full"},  int'(full),     (m_count == NE) ? 1 : 0);
    chk({tag, "_empty"}, int'(empty),    (m_count == 0) ? 1 : 0);
    chk({tag, "_err"},   int'(rel_err),  m_err);
  endtask

  // One clock: drive, check combinational grant/tags, clock, advance model, check state.
  task automatic cyc(input string tag, input bit rst, input logic [NR-1:0] req,
                     input int rel, input bit fl);
    int  total;
    int  k;
    bit  grant;
    bit  legal;
    rst_n     = !rst;
    req_valid = req;
    rel_cnt   = CW'(rel);
    flush     = fl;
    #2;
    total = $countones(req);
    grant = !fl && (total <= NE - m_count);
    legal = (rel <= m_count);
    if (!rst) begin
      chk({tag, "_grant"}, int'(alloc_grant), int'(grant));
      if (grant) begin
        k = 0;
        for (int i = 0; i < NR; i++) begin
          if (req[i]) begin
            chk($sformatf("%s_tag%0d", tag, i), int'(alloc_tag[i*PW +: PW]), (m_tail + k) % NE);
            k++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
    end else if (fl) begin
      m_head = m_tail; m_count = 0; m_err = 0;
    end else begin
      if (grant) begin
        m_tail  = (m_tail + total) % NE;
        m_count = m_count + total;
      end
      if (legal) begin
        m_head  = (m_head + rel) % NE;
        m_count = m_count - rel;
      end
      m_err = legal ? 0 : 1;
    end
    chk_state(tag);
  endtask

  initial begin
    int old_tail;
    int r;
    rst_n = 1'b0; req_valid = '0; rel_cnt = '0; flush = 1'b0;

    // Reset with competing flush and full request mask
    cyc("reset", 1, 4'b1111, 0, 1);
    chk("reset_empty_const", int'(empty), 1);

    // Sparse pack from tail 0
    cyc("sparse", 0, 4'b1011, 0, 0);
    chk("sparse_tail_const", int'(tail_ptr), 3);
    chk("sparse_count_const", int'(count), 3);

    // Fill from empty and overflow attempt
    cyc("rst2", 1, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) cyc("fill", 0, 4'b1111, 0, 0);
    chk("fill_full_const", int'(full), 1);
    chk("fill_tail_const", int'(tail_ptr), 0);
    cyc("overflow", 0, 4'b0001, 0, 0);
    chk("overflow_count_const", int'(count), 16);

    // Release while full: no grant even though entries retire this cycle
    cyc("simul", 0, 4'b0011, 2, 0);
    chk("simul_count_const", int'(count), 14);
    chk("simul_head_const", int'(head_ptr), 2);

    // Set up head=12 tail=14 count=2 then wrap allocation
    cyc("rst3", 1, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pre", 0, 4'b1111, 0, 0);
    cyc("pre", 0, 4'b0011, 0, 0);
    for (int i = 0; i < 3; i++) cyc("drain", 0, 4'b0000, 4, 0);
    cyc("wrap", 0, 4'b1111, 0, 0);
    chk("wrap_tail_const", int'(tail_ptr), 2);
    chk("wrap_count_const", int'(count), 6);

    // Flush with competing allocate and release at count 5
    cyc("to5", 0, 4'b0000, 1, 0);
    old_tail = int'(tail_ptr);
    cyc("flush", 0, 4'b1111, 1, 1);
    chk("flush_head_eq_old_tail", int'(head_ptr), old_tail);

    // Illegal release: one-cycle error pulse
    cyc("to2", 0, 4'b0110, 0, 0);
    cyc("illegal", 0, 4'b0000, 3, 0);
    chk("illegal_err_const", int'(rel_err), 1);
    cyc("after_err", 0, 4'b0000, 0, 0);
    chk("after_err_const", int'(rel_err), 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 31));
      cyc("rand", (r == 0), 4'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
          (r == 1 || r == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
